// File: rtl/uart_mem_loader_if.sv
// uart_mem_loader_if: data-memory write port (writeEn strobe, word address, write data)
interface uart_mem_loader_if;
  logic        writeEn;
  logic [31:0] address;
  logic [31:0] dataIn;
  modport master (output writeEn, address, dataIn);
  modport slave (input writeEn, address, dataIn);
endinterface

// File: rtl/uart_mem_loader.sv
// uart_mem_loader: 8N1 UART receiver packing 4 bytes per little-endian word into data-memory writes
// ports: clk, rst_n (sync, active-low), RxD (async serial in), enable (accept bytes),
//        mem (writeEn/address/dataIn write port), busy (frame in progress),
//        done (sticky, all words written), frameError (sticky, low stop bit seen)
module uart_mem_loader #(
  parameter int CLKS_PER_BIT = 434,
  parameter int WORD_COUNT   = 1024
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               RxD,
  input  logic               enable,
  uart_mem_loader_if.master  mem,
  output logic               busy,
  output logic               done,
  output logic               frameError
);
  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int CW   = $clog2(CLKS_PER_BIT);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state, state_n;
  logic rx_m, rx_s, tick, drop, byte_ok, last;
  logic [CW-1:0] cnt;
  logic [2:0] bit_idx;
  logic [7:0] shift;
  logic [1:0] idx;
  logic [23:0] word;
  logic [9:0] wcnt;
  always_ff @(posedge clk)
    if (!rst_n) {rx_m, rx_s} <= 2'b11;
    else {rx_m, rx_s} <= {RxD, rx_m};
  always_ff @(posedge clk)
    state <= rst_n ? state_n : IDLE;
  assign tick = cnt == (state == START ? CW'(HALF - 1) : CW'(CLKS_PER_BIT - 1));
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = (!rx_s && enable && !done) ? START : IDLE;
      START:   state_n = tick ? (rx_s ? IDLE : DATA) : START;
      DATA:    state_n = (tick && bit_idx == 3'd7) ? STOP : DATA;
      default: state_n = tick ? IDLE : STOP;
    endcase
  end
  // drop marks a frame during which enable was seen low; its byte is thrown away
  always_ff @(posedge clk)
    if (!rst_n) begin
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
      drop    <= 1'b0;
    end else begin
      cnt     <= (state == IDLE || tick) ? '0 : cnt + CW'(1);
      bit_idx <= state == START ? 3'd0 : (state == DATA && tick) ? bit_idx + 3'd1 : bit_idx;
      if (state == DATA && tick) shift <= {rx_s, shift[7:1]};
      drop    <= state == IDLE ? 1'b0 : drop | ~enable;
    end
  assign busy    = state != IDLE;
  assign byte_ok = state == STOP && tick && rx_s && !drop && enable;
  assign last    = wcnt == 10'(WORD_COUNT - 1);
  // bytes shift in from the top so the first byte ends up in the low lane
  always_ff @(posedge clk)
    if (!rst_n) begin
      mem.writeEn <= 1'b0;
      mem.address <= '0;
      mem.dataIn  <= '0;
      done        <= 1'b0;
      frameError  <= 1'b0;
      idx         <= '0;
      word        <= '0;
      wcnt        <= '0;
    end else begin
      mem.writeEn <= 1'b0;
      if (state == STOP && tick && !rx_s) frameError <= 1'b1;
      if (!enable) begin
        idx  <= '0;
        word <= '0;
      end else if (byte_ok) begin
        idx  <= idx + 2'd1;
        word <= {shift, word[23:8]};
        if (idx == 2'd3) begin
          mem.writeEn <= 1'b1;
          mem.address <= {22'd0, wcnt};
          mem.dataIn  <= {shift, word};
          wcnt        <= last ? wcnt : wcnt + 10'd1;
          done        <= last;
        end
      end
    end
endmodule

// File: tb/tb_uart_mem_loader.sv
// tb_uart_mem_loader: randomized and directed checks of uart_mem_loader against a byte-stream model
module tb_uart_mem_loader;
  localparam int CPB = 8;
  logic clk = 1'b0, rst_n = 1'b0, rxd = 1'b1, enable = 1'b0;
  logic busy1, done1, fe1, busy2, done2, fe2;
  uart_mem_loader_if mif1();
  uart_mem_loader_if mif2();
  always #5 clk = ~clk;
  uart_mem_loader #(.CLKS_PER_BIT(CPB), .WORD_COUNT(1024)) dut1 (
    .clk(clk), .rst_n(rst_n), .RxD(rxd), .enable(enable), .mem(mif1),
    .busy(busy1), .done(done1), .frameError(fe1));
  uart_mem_loader #(.CLKS_PER_BIT(CPB), .WORD_COUNT(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .RxD(rxd), .enable(enable), .mem(mif2),
    .busy(busy2), .done(done2), .frameError(fe2));
  logic [31:0] oa1[$], od1[$], oa2[$], od2[$];
  int busy_cyc1 = 0, busy_done2 = 0;
  always @(negedge clk) begin
    if (mif1.writeEn) begin oa1.push_back(mif1.address); od1.push_back(mif1.dataIn); end
    if (mif2.writeEn) begin oa2.push_back(mif2.address); od2.push_back(mif2.dataIn); end
    if (busy1) busy_cyc1++;
    if (busy2 && done2) busy_done2++;
  end
  logic [7:0] part[$];
  logic [31:0] exp_d[$];
  bit merr1, merr2;
  int base1, base2, n_cmp = 0, n_err = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic do_reset(input int cyc);
    @(negedge clk);
    rst_n = 1'b0;
    rxd = 1'b1;
    repeat (cyc) @(negedge clk);
    rst_n = 1'b1;
    part.delete();
    exp_d.delete();
    merr1 = 0;
    merr2 = 0;
    base1 = oa1.size();
    base2 = oa2.size();
  endtask
  task automatic set_en(input bit v);
    if (enable && !v) part.delete();
    enable = v;
  endtask
  task automatic send(input logic [7:0] b, input bit ok, input int idle, input bit glitch);
    bit s1 = enable && exp_d.size() < 1024;
    bit s2 = enable && exp_d.size() < 2;
    bit g = glitch && enable;
    logic [9:0] fr = {ok, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rxd = fr[i];
      if (i == 9 && !ok) begin
        repeat (CPB - 2) @(negedge clk);
        rxd = 1'b1;
        repeat (2) @(negedge clk);
      end else if (i == 4 && g) begin
        repeat (3) @(negedge clk);
        enable = 1'b0;
        repeat (3) @(negedge clk);
        enable = 1'b1;
        repeat (CPB - 6) @(negedge clk);
      end else repeat (CPB) @(negedge clk);
    end
    rxd = 1'b1;
    repeat (idle * CPB) @(negedge clk);
    if (g) part.delete();
    if (s1 && !ok) merr1 = 1;
    if (s2 && !ok) merr2 = 1;
    if (s1 && ok && !g) begin
      part.push_back(b);
      if (part.size() == 4) begin
        exp_d.push_back({part[3], part[2], part[1], part[0]});
        part.delete();
      end
    end
  endtask
  task automatic check_all(input string tag);
    int n1, n2, e2;
    repeat (2 * CPB) @(negedge clk);
    n1 = oa1.size() - base1;
    n2 = oa2.size() - base2;
    e2 = exp_d.size() < 2 ? exp_d.size() : 2;
    chk({tag, "/nwr1"}, n1, exp_d.size());
    for (int i = 0; i < n1 && i < exp_d.size(); i++) begin
      chk({tag, "/addr1"}, oa1[base1 + i], i);
      chk({tag, "/data1"}, od1[base1 + i], exp_d[i]);
    end
    chk({tag, "/nwr2"}, n2, e2);
    for (int i = 0; i < n2 && i < e2; i++) begin
      chk({tag, "/addr2"}, oa2[base2 + i], i);
      chk({tag, "/data2"}, od2[base2 + i], exp_d[i]);
    end
    if (exp_d.size() > 0) begin
      chk({tag, "/hold_addr"}, mif1.address, exp_d.size() - 1);
      chk({tag, "/hold_data"}, mif1.dataIn, exp_d[exp_d.size() - 1]);
    end
    chk({tag, "/done1"}, done1, exp_d.size() >= 1024);
    chk({tag, "/done2"}, done2, exp_d.size() >= 2);
    chk({tag, "/ferr1"}, fe1, merr1);
    chk({tag, "/ferr2"}, fe2, merr2);
    chk({tag, "/busy1"}, busy1, 0);
    chk({tag, "/busy2"}, busy2, 0);
  endtask
  initial begin
    int b0, d0;
    do_reset(3);
    chk("rst/we", mif1.writeEn, 0);
    chk("rst/addr", mif1.address, 0);
    chk("rst/data", mif1.dataIn, 0);
    chk("rst/busy", busy1, 0);
    chk("rst/done", done1, 0);
    chk("rst/ferr", fe1, 0);
    set_en(1);
    repeat (2 * CPB) @(negedge clk);
    send(8'h78, 1, 1, 0); send(8'h56, 1, 1, 0); send(8'h34, 1, 1, 0); send(8'h12, 1, 1, 0);
    check_all("word");
    do_reset(2);
    for (int i = 1; i <= 8; i++) send(8'(i), 1, i == 8 ? 1 : 0, 0);
    check_all("b2b");
    do_reset(2);
    send(8'hAA, 0, 1, 0);
    send(8'h11, 1, 0, 0); send(8'h22, 1, 0, 0); send(8'h33, 1, 0, 0); send(8'h44, 1, 1, 0);
    check_all("ferr");
    do_reset(2);
    b0 = busy_cyc1;
    rxd = 1'b0;
    repeat (2) @(negedge clk);
    rxd = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    chk("glitch/busy_cyc", busy_cyc1 - b0, CPB / 2);
    check_all("glitch");
    do_reset(2);
    d0 = busy_done2;
    for (int i = 0; i < 12; i++) send(8'($urandom), 1, $urandom_range(0, 1), 0);
    check_all("wc2");
    chk("wc2/busy_after_done", busy_done2 - d0, 0);
    do_reset(2);
    send(8'($urandom), 1, 0, 0);
    send(8'($urandom), 1, 0, 0);
    begin
      logic [7:0] pb = 8'($urandom);
      rxd = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 4; i++) begin rxd = pb[i]; repeat (CPB) @(negedge clk); end
    end
    do_reset(1);
    repeat (12 * CPB) @(negedge clk);
    send(8'hEF, 1, 0, 0); send(8'hBE, 1, 0, 0); send(8'hAD, 1, 0, 0); send(8'hDE, 1, 1, 0);
    check_all("midrst");
    chk("midrst/word", exp_d.size() > 0 ? exp_d[0] : 32'h0, 32'hDEADBEEF);
    do_reset(2);
    send(8'h5A, 1, 1, 0); send(8'hA5, 1, 1, 0);
    set_en(0);
    repeat (CPB) @(negedge clk);
    set_en(1);
    send(8'hC1, 1, 0, 0); send(8'hC2, 1, 0, 0); send(8'hC3, 1, 0, 0); send(8'hC4, 1, 1, 0);
    send(8'h9F, 1, 1, 1);
    check_all("enable");
    do_reset(2);
    for (int i = 0; i < 48; i++) begin
      set_en($urandom_range(0, 5) != 0);
      send(8'($urandom), $urandom_range(0, 7) != 0, $urandom_range(0, 2), $urandom_range(0, 9) == 0);
    end
    set_en(1);
    check_all("rand");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/uart_mem_loader.md
# uart_mem_loader

UART receive-side loader for the data memory: deserialises 8N1 bytes from an external `RxD` line, packs every four bytes into a 32-bit little-endian word, and issues single-cycle writes on the data memory's `writeEn`/`address`/`dataIn` port at consecutive word addresses. It is the inbound counterpart of the memory-dump transmitter path and lets the host preload memory contents before the CPU runs.

## Interface
- `CLKS_PER_BIT`, 434, clock cycles per UART bit (50 MHz / 115200); must be >= 4.
- `WORD_COUNT`, 1024, number of words loaded before `done`; must be <= 1024.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `RxD`  in  1  asynchronous serial input, idle high.
- `enable`  in  1  level; loader accepts bytes only while high.
- `writeEn`  out  1  one-cycle memory write strobe.
- `address`  out  32  word address of the write; bits [31:10] always 0.
- `dataIn`  out  32  word to write; valid whenever `writeEn` = 1.
- `busy`  out  1  high from start-bit acceptance until the stop bit is sampled.
- `done`  out  1  sticky; high once `WORD_COUNT` words have been written.
- `frameError`  out  1  sticky; set on a stop bit sampled low.

## Operation
- `RxD` passes through a 2-flop synchroniser (reset value 1); the FSM uses only the synchronised bit `rx_s`.
- RX FSM states: IDLE, START, DATA, STOP.
  - IDLE: on `rx_s` = 0 while `enable` = 1 and `done` = 0, go to START with the bit counter cleared.
  - START: after `CLKS_PER_BIT/2` cycles, re-sample. If 0, go to DATA; if 1, treat it as a glitch and return to IDLE with no error.
  - DATA: sample every `CLKS_PER_BIT` cycles, LSB first, into the shift register. After bit 7, go to STOP.
  - STOP: after `CLKS_PER_BIT` cycles, sample. If 1, the byte is valid. If 0, set `frameError`, discard the byte, and leave the word assembler unchanged. Go to IDLE in both cases.
- Word assembler:
  - A 2-bit byte index places a valid byte into `word[8*idx +: 8]` (first byte goes to [7:0]).
  - On the 4th valid byte, the next cycle drives `writeEn` = 1, `dataIn` = assembled word and `address` = word counter.
  - In that same cycle, the word counter increments and the byte index wraps to 0.
- Word counter: 10-bit, starts at 0. When it reaches `WORD_COUNT`, `done` is set and the IDLE start condition is blocked. The counter never wraps past `WORD_COUNT - 1`.
- `enable` falling:
  - Any frame in progress still completes, but its byte is discarded.
  - Byte index and partial word are cleared.
  - Word counter is kept, so re-enabling continues at the next address.
- `enable` has no effect on `done` or `frameError`; only reset clears them.

## Timing
- Reset values (`rst_n` = 0 at a clock edge): FSM = IDLE; `writeEn` 0; `address` 0; `dataIn` 0; `busy` 0; `done` 0; `frameError` 0; byte index 0; word counter 0; synchroniser flops 1.
- Reset mid-frame or mid-word abandons everything with no write.
- Start detection lags the `RxD` falling edge by 2 cycles (synchroniser).
- Samples land at bit-centre ±1 cycle.
- `writeEn` is high for exactly 1 cycle, 1 cycle after the stop-bit sample of the 4th byte.
- `address` and `dataIn` hold their last written values between strobes.
- STOP returns to IDLE at the stop-bit centre, so back-to-back frames with zero idle time are accepted.
- `busy` rises in the cycle START is entered and falls in the cycle STOP exits.
- `done` rises in the same cycle as the final `writeEn`.
- Worst-case write rate is one word per 40 bit times. No backpressure: the memory port must accept a write every cycle `writeEn` is high.

## Test plan
- Byte stream 0x78, 0x56, 0x34, 0x12 (`CLKS_PER_BIT` = 8) -> one `writeEn` pulse with `address` = 0, `dataIn` = 0x12345678; `busy` low afterwards.
- 8 back-to-back bytes 0x01..0x08 with no idle bits -> writes (0, 0x04030201) then (1, 0x08070605); exactly 2 pulses.
- Byte 0xAA with stop bit forced 0, then 0x11, 0x22, 0x33, 0x44 -> `frameError` = 1; single write (0, 0x44332211).
- 2-cycle low glitch on idle `RxD` -> no state change, no error, `busy` pulses only while in START.
- `WORD_COUNT` = 2, 12 bytes sent -> writes at addresses 0 and 1 only; `done` = 1 from the 2nd write; remaining bytes ignored and `busy` stays 0.
- `rst_n` low for 1 cycle mid-DATA of byte 3, then 0xEF, 0xBE, 0xAD, 0xDE -> single write (0, 0xDEADBEEF); `frameError` 0.
